membus_arbiter: RTL and testbench

//  Shares the single memory bus (meminf::MemBusReq/MemBusResp) between the instruction-side and

---
 rtl/membus_arbiter.sv | 157 +++++++++++++++
 tb/tb_membus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the icache and dcache refill engines.
// Optional response timeout is enabled by defining MEMBUS_ARB_TIMEOUT_EN.
module membus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        i_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_wdata,
   output logic        i_resp_valid,
   output logic        i_resp_error,
   output logic [31:0] i_resp_addr,
   output logic [31:0] i_resp_rdata,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_wen,
   input  logic [31:0] d_req_wdata,
   output logic        d_resp_valid,
   output logic        d_resp_error,
   output logic [31:0] d_resp_addr,
   output logic [31:0] d_resp_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic        mem_resp_error,
   input  logic [31:0] mem_resp_addr,
   input  logic [31:0] mem_resp_rdata
);

   // state   | meaning
   // ST_IDLE | no transaction outstanding, grant evaluated every cycle
   // ST_WAIT | one transaction accepted, waiting for its response
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t state;
   logic   owner;       // 0 = icache, 1 = dcache
   logic   last_owner;
   logic   grant_d;
   logic   accept;
   logic   resp_fire;
   logic   resp_error;
   logic [31:0] resp_addr;
   logic [31:0] resp_rdata;
   logic   drop_pending;
   logic   timeout_hit;

`ifdef MEMBUS_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   req_addr_q;
   logic          drop_q;

   assign drop_pending = drop_q;
   assign timeout_hit  = (state == ST_WAIT) && !mem_resp_valid &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign drop_pending = 1'b0;
   assign timeout_hit  = 1'b0;
`endif

   always_comb begin
      grant_d       = (i_req_valid && d_req_valid) ? ~last_owner : d_req_valid;
      mem_req_valid = (state == ST_IDLE) && !drop_pending && (i_req_valid || d_req_valid);
      mem_req_addr  = '0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      if (mem_req_valid) begin
         mem_req_addr  = grant_d ? d_req_addr  : i_req_addr;
         mem_req_wen   = grant_d ? d_req_wen   : i_req_wen;
         mem_req_wdata = grant_d ? d_req_wdata : i_req_wdata;
      end
      i_req_ready = mem_req_valid && !grant_d && mem_req_ready;
      d_req_ready = mem_req_valid &&  grant_d && mem_req_ready;
      accept      = mem_req_valid && mem_req_ready;

      resp_fire  = (state == ST_WAIT) && (mem_resp_valid || timeout_hit);
      resp_error = 1'b0;
      resp_addr  = '0;
      resp_rdata = '0;
      if (resp_fire) begin
         if (mem_resp_valid) begin
            resp_error = mem_resp_error;
            resp_addr  = mem_resp_addr;
            resp_rdata = mem_resp_rdata;
         end else begin
            resp_error = 1'b1;
`ifdef MEMBUS_ARB_TIMEOUT_EN
            resp_addr  = req_addr_q;
`endif
         end
      end

      i_resp_valid = resp_fire && !owner;
      i_resp_error = i_resp_valid ? resp_error : 1'b0;
      i_resp_addr  = i_resp_valid ? resp_addr  : '0;
      i_resp_rdata = i_resp_valid ? resp_rdata : '0;
      d_resp_valid = resp_fire && owner;
      d_resp_error = d_resp_valid ? resp_error : 1'b0;
      d_resp_addr  = d_resp_valid ? resp_addr  : '0;
      d_resp_rdata = d_resp_valid ? resp_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
`ifdef MEMBUS_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
         req_addr_q <= '0;
         drop_q     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
`ifdef MEMBUS_ARB_TIMEOUT_EN
               if (drop_q && mem_resp_valid)
                  drop_q <= 1'b0;
`endif
               if (accept) begin
                  owner      <= grant_d;
                  last_owner <= grant_d;
                  state      <= ST_WAIT;
`ifdef MEMBUS_ARB_TIMEOUT_EN
                  wait_cnt   <= '0;
                  req_addr_q <= mem_req_addr;
`endif
               end
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  state <= ST_IDLE;
               end else if (timeout_hit) begin
                  state <= ST_IDLE;
`ifdef MEMBUS_ARB_TIMEOUT_EN
                  drop_q <= 1'b1;
`endif
               end
`ifdef MEMBUS_ARB_TIMEOUT_EN
               else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed, table-driven bench for membus_arbiter; the timeout sequence runs when
// MEMBUS_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES overridden to 8).
module tb_membus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 0, i_req_wen = 0;
   logic [31:0] i_req_addr = 0, i_req_wdata = 0;
   logic        d_req_valid = 0, d_req_wen = 0;
   logic [31:0] d_req_addr = 0, d_req_wdata = 0;
   logic        mem_req_ready = 0, mem_resp_valid = 0, mem_resp_error = 0;
   logic [31:0] mem_resp_addr = 0, mem_resp_rdata = 0;
   logic        i_req_ready, i_resp_valid, i_resp_error;
   logic [31:0] i_resp_addr, i_resp_rdata;
   logic        d_req_ready, d_resp_valid, d_resp_error;
   logic [31:0] d_resp_addr, d_resp_rdata;
   logic        mem_req_valid, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   membus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_req_wen(i_req_wen), .i_req_wdata(i_req_wdata),
      .i_resp_valid(i_resp_valid), .i_resp_error(i_resp_error),
      .i_resp_addr(i_resp_addr), .i_resp_rdata(i_resp_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_error(d_resp_error),
      .d_resp_addr(d_resp_addr), .d_resp_rdata(d_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_error(mem_resp_error),
      .mem_resp_addr(mem_resp_addr), .mem_resp_rdata(mem_resp_rdata)
   );

   // ctl = {i_req_ready, d_req_ready, mem_req_valid, mem_req_wen,
   //        i_resp_valid, i_resp_error, d_resp_valid, d_resp_error}
   typedef struct {
      logic        rst;
      logic        iv;  logic [31:0] ia; logic iw; logic [31:0] iwd;
      logic        dv;  logic [31:0] da; logic dw; logic [31:0] dwd;
      logic        mrdy;
      logic        rv;  logic re; logic [31:0] ra; logic [31:0] rd;
      logic [7:0]  ectl;
      logic [31:0] ema, emd, era, erd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic iv, input logic [31:0] ia, input logic iw,
                      input logic [31:0] iwd, input logic dv, input logic [31:0] da,
                      input logic dw, input logic [31:0] dwd, input logic mrdy,
                      input logic rv, input logic re, input logic [31:0] ra,
                      input logic [31:0] rd, input logic [7:0] ectl,
                      input logic [31:0] ema, input logic [31:0] emd,
                      input logic [31:0] era, input logic [31:0] erd);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ia = ia; v.iw = iw; v.iwd = iwd;
      v.dv = dv; v.da = da; v.dw = dw; v.dwd = dwd; v.mrdy = mrdy;
      v.rv = rv; v.re = re; v.ra = ra; v.rd = rd;
      v.ectl = ectl; v.ema = ema; v.emd = emd; v.era = era; v.erd = erd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_req_valid = 0; i_req_addr = 0; i_req_wen = 0; i_req_wdata = 0;
      d_req_valid = 0; d_req_addr = 0; d_req_wen = 0; d_req_wdata = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_error = 0;
      mem_resp_addr = 0; mem_resp_rdata = 0;
   endtask

   initial begin
      logic [7:0] ctl;
      // reset
      add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 8'b0000_0000, 0,0,0,0);
      // single I read, memory ready after 2 cycles
      add(1, 1,32'h8000_0000,0,0, 0,0,0,0, 0, 0,0,0,0, 8'b0010_0000, 32'h8000_0000,0,0,0);
      add(1, 1,32'h8000_0000,0,0, 0,0,0,0, 0, 0,0,0,0, 8'b0010_0000, 32'h8000_0000,0,0,0);
      add(1, 1,32'h8000_0000,0,0, 0,0,0,0, 1, 0,0,0,0, 8'b1010_0000, 32'h8000_0000,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 8'b0000_0000, 0,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,0,32'h8000_0000,32'h1234_5678,
          8'b0000_1000, 0,0,32'h8000_0000,32'h1234_5678);
      // spurious response in IDLE
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,0,32'h0000_0bad,32'h0000_ffff, 8'b0000_0000, 0,0,0,0);
      // contention: D, I, D after I was last owner
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 0,0,0,0, 8'b0110_0000, 32'h200,0,0,0);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 0,0,0,0, 8'b0000_0000, 0,0,0,0);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 1,0,32'h200,32'haaaa_0001,
          8'b0000_0010, 0,0,32'h200,32'haaaa_0001);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 0,0,0,0, 8'b1010_0000, 32'h100,0,0,0);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 1,0,32'h100,32'hbbbb_0002,
          8'b0000_1000, 0,0,32'h100,32'hbbbb_0002);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 0,0,0,0, 8'b0110_0000, 32'h200,0,0,0);
      add(1, 1,32'h100,0,0, 1,32'h200,0,0, 1, 1,0,32'h200,32'hcccc_0003,
          8'b0000_0010, 0,0,32'h200,32'hcccc_0003);
      // D write, I held off during WAIT
      add(1, 0,0,0,0, 1,32'h300,1,32'hdead_beef, 1, 0,0,0,0,
          8'b0111_0000, 32'h300,32'hdead_beef,0,0);
      add(1, 1,32'h400,0,0, 0,0,0,0, 1, 0,0,0,0, 8'b0000_0000, 0,0,0,0);
      add(1, 1,32'h400,0,0, 0,0,0,0, 1, 1,0,32'h300,0, 8'b0000_0010, 0,0,32'h300,0);
      // D read error, then next D read accepted normally
      add(1, 0,0,0,0, 1,32'h500,0,0, 1, 0,0,0,0, 8'b0110_0000, 32'h500,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,1,32'h500,0, 8'b0000_0011, 0,0,32'h500,0);
      add(1, 0,0,0,0, 1,32'h504,0,0, 1, 0,0,0,0, 8'b0110_0000, 32'h504,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,0,32'h504,32'h5555_0504,
          8'b0000_0010, 0,0,32'h504,32'h5555_0504);
      // reset mid-WAIT, late response ignored, last_owner back to D
      add(1, 1,32'h600,0,0, 0,0,0,0, 1, 0,0,0,0, 8'b1010_0000, 32'h600,0,0,0);
      add(0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 8'b0000_0000, 0,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,0,32'h600,32'h77, 8'b0000_0000, 0,0,0,0);
      add(1, 1,32'h704,0,0, 1,32'h700,0,0, 1, 0,0,0,0, 8'b1010_0000, 32'h704,0,0,0);
      add(1, 0,0,0,0, 1,32'h700,0,0, 0, 1,0,32'h704,32'h704, 8'b0000_1000, 0,0,32'h704,32'h704);
      add(1, 0,0,0,0, 1,32'h700,0,0, 1, 0,0,0,0, 8'b0110_0000, 32'h700,0,0,0);
      add(1, 0,0,0,0, 0,0,0,0, 0, 1,0,32'h700,32'h1, 8'b0000_0010, 0,0,32'h700,32'h1);

      foreach (vecs[k]) begin
         @(negedge clk);
         rst_n = vecs[k].rst;
         i_req_valid = vecs[k].iv; i_req_addr = vecs[k].ia;
         i_req_wen = vecs[k].iw; i_req_wdata = vecs[k].iwd;
         d_req_valid = vecs[k].dv; d_req_addr = vecs[k].da;
         d_req_wen = vecs[k].dw; d_req_wdata = vecs[k].dwd;
         mem_req_ready = vecs[k].mrdy;
         mem_resp_valid = vecs[k].rv; mem_resp_error = vecs[k].re;
         mem_resp_addr = vecs[k].ra; mem_resp_rdata = vecs[k].rd;
         #1;
         ctl = {i_req_ready, d_req_ready, mem_req_valid, mem_req_wen,
                i_resp_valid, i_resp_error, d_resp_valid, d_resp_error};
         chk($sformatf("v%0d ctl", k), {24'h0, ctl}, {24'h0, vecs[k].ectl});
         chk($sformatf("v%0d mem_req_addr", k), mem_req_addr, vecs[k].ema);
         chk($sformatf("v%0d mem_req_wdata", k), mem_req_wdata, vecs[k].emd);
         chk($sformatf("v%0d i_resp_addr", k), i_resp_addr, vecs[k].ectl[3] ? vecs[k].era : 32'h0);
         chk($sformatf("v%0d i_resp_rdata", k), i_resp_rdata, vecs[k].ectl[3] ? vecs[k].erd : 32'h0);
         chk($sformatf("v%0d d_resp_addr", k), d_resp_addr, vecs[k].ectl[1] ? vecs[k].era : 32'h0);
         chk($sformatf("v%0d d_resp_rdata", k), d_resp_rdata, vecs[k].ectl[1] ? vecs[k].erd : 32'h0);
      end

`ifdef MEMBUS_ARB_TIMEOUT_EN
      // I read never answered: error response at WAIT cycle 8, late response dropped
      @(negedge clk); idle_inputs();
      i_req_valid = 1; i_req_addr = 32'h900; mem_req_ready = 1;
      #1 chk("to accept", {31'h0, i_req_ready}, 32'h1);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk); idle_inputs();
         #1 chk($sformatf("to wait%0d i_resp_valid", c), {31'h0, i_resp_valid}, 32'h0);
      end
      @(negedge clk); idle_inputs();
      #1;
      chk("to resp ctl", {28'h0, i_resp_valid, i_resp_error, d_resp_valid, d_resp_error}, 32'hc);
      chk("to resp addr", i_resp_addr, 32'h900);
      chk("to resp rdata", i_resp_rdata, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); idle_inputs();
         d_req_valid = 1; d_req_addr = 32'ha00; mem_req_ready = 1;
         #1 chk($sformatf("to blocked%0d", c), {30'h0, d_req_ready, mem_req_valid}, 32'h0);
      end
      @(negedge clk);
      mem_resp_valid = 1; mem_resp_addr = 32'h900; mem_resp_rdata = 32'h1234;
      #1 chk("to late resp", {29'h0, i_resp_valid, d_resp_valid, d_req_ready}, 32'h0);
      @(negedge clk);
      mem_resp_valid = 0; mem_resp_addr = 0; mem_resp_rdata = 0;
      #1;
      chk("to regrant ready", {31'h0, d_req_ready}, 32'h1);
      chk("to regrant addr", mem_req_addr, 32'ha00);
      @(negedge clk); idle_inputs();
      mem_resp_valid = 1; mem_resp_addr = 32'ha00; mem_resp_rdata = 32'h42;
      #1;
      chk("to d resp valid", {31'h0, d_resp_valid}, 32'h1);
      chk("to d resp rdata", d_resp_rdata, 32'h42);
`else
      // Without the timeout, WAIT holds indefinitely until the response arrives
      @(negedge clk); idle_inputs();
      d_req_valid = 1; d_req_addr = 32'hb00; mem_req_ready = 1;
      #1 chk("hold accept", {31'h0, d_req_ready}, 32'h1);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); idle_inputs();
         i_req_valid = 1; i_req_addr = 32'hc00; mem_req_ready = 1;
         #1 chk($sformatf("hold%0d", c),
                {28'h0, i_resp_valid, d_resp_valid, i_req_ready, mem_req_valid}, 32'h0);
      end
      @(negedge clk); idle_inputs();
      mem_resp_valid = 1; mem_resp_addr = 32'hb00; mem_resp_rdata = 32'h99;
      #1;
      chk("hold d resp", {30'h0, d_resp_valid, i_resp_valid}, 32'h2);
      chk("hold d rdata", d_resp_rdata, 32'h99);
      @(negedge clk); idle_inputs();
      i_req_valid = 1; i_req_addr = 32'hc00; mem_req_ready = 1;
      #1 chk("hold regrant i", {31'h0, i_req_ready}, 32'h1);
`endif

      @(negedge clk); idle_inputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
